// File: rtl/alu_reservation_station.sv
// Operand-capturing reservation station for the ALU; issues the oldest ready entry.
// Optional: RS_DISPATCH_FWD_EN lets a dispatching operand capture a same-edge result broadcast.
module alu_reservation_station #(
  parameter int RS_DEPTH     = 4,
  parameter int ROB_IDX_SIZE = 5,
  parameter int GPR_SIZE     = 32,
  parameter int FU_OP_SIZE   = 4,
  parameter int NZCV_SIZE    = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_flush,
  input  logic                    in_dispatch_valid,
  input  logic [FU_OP_SIZE-1:0]   in_dispatch_fu_op,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_dst_rob_index,
  input  logic                    in_dispatch_set_nzcv,
  input  logic [NZCV_SIZE-1:0]    in_dispatch_nzcv,
  input  logic                    in_dispatch_a_ready,
  input  logic                    in_dispatch_b_ready,
  input  logic [GPR_SIZE-1:0]     in_dispatch_a_val,
  input  logic [GPR_SIZE-1:0]     in_dispatch_b_val,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_a_tag,
  input  logic [ROB_IDX_SIZE-1:0] in_dispatch_b_tag,
  output logic                    out_dispatch_ready,
  input  logic                    in_fu_done,
  input  logic [ROB_IDX_SIZE-1:0] in_fu_dst_rob_index,
  input  logic [GPR_SIZE-1:0]     in_fu_value,
  input  logic                    in_fu_ready,
  output logic                    out_fu_start,
  output logic [FU_OP_SIZE-1:0]   out_fu_fu_op,
  output logic [GPR_SIZE-1:0]     out_fu_val_a,
  output logic [GPR_SIZE-1:0]     out_fu_val_b,
  output logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index,
  output logic                    out_fu_set_nzcv,
  output logic [NZCV_SIZE-1:0]    out_fu_nzcv
);
  localparam int RW = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RS_DEPTH);

  typedef struct packed {
    logic                    valid;
    logic [FU_OP_SIZE-1:0]   op;
    logic [ROB_IDX_SIZE-1:0] dst;
    logic                    set_nzcv;
    logic [NZCV_SIZE-1:0]    nzcv;
    logic                    a_rdy;
    logic [GPR_SIZE-1:0]     a_val;
    logic [ROB_IDX_SIZE-1:0] a_tag;
    logic                    b_rdy;
    logic [GPR_SIZE-1:0]     b_val;
    logic [ROB_IDX_SIZE-1:0] b_tag;
    logic [RW-1:0]           rank;
  } entry_t;

  entry_t entry_q [RS_DEPTH];
  entry_t entry_d [RS_DEPTH];

  logic                    fu_start_q, fu_start_d;
  logic [FU_OP_SIZE-1:0]   fu_op_q, fu_op_d;
  logic [GPR_SIZE-1:0]     val_a_q, val_a_d, val_b_q, val_b_d;
  logic [ROB_IDX_SIZE-1:0] dst_q, dst_d;
  logic                    set_nzcv_q, set_nzcv_d;
  logic [NZCV_SIZE-1:0]    nzcv_q, nzcv_d;

  logic [CW-1:0]       occ;
  logic [RS_DEPTH-1:0] elig, sel_oh, free_oh;
  logic                any_elig, any_free;
  logic [RW-1:0]       sel_rank, new_rank;
  logic                do_issue, do_dispatch;
  logic                fwd_a, fwd_b;

  always_comb begin
    occ      = '0;
    elig     = '0;
    any_elig = 1'b0;
    sel_rank = '0;
    free_oh  = '0;
    any_free = 1'b0;
    sel_oh   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      occ     = occ + CW'(entry_q[i].valid);
      elig[i] = entry_q[i].valid & entry_q[i].a_rdy & entry_q[i].b_rdy;
      if (elig[i] && (!any_elig || entry_q[i].rank < sel_rank)) begin
        any_elig = 1'b1;
        sel_rank = entry_q[i].rank;
      end
      if (!entry_q[i].valid && !any_free) begin
        free_oh[i] = 1'b1;
        any_free   = 1'b1;
      end
    end
    // Ranks of valid entries are unique, so this match is one-hot.
    for (int i = 0; i < RS_DEPTH; i++)
      sel_oh[i] = elig[i] && (entry_q[i].rank == sel_rank);
  end

  assign out_dispatch_ready = (occ < DEPTH_C);
  assign do_dispatch = in_dispatch_valid & out_dispatch_ready & ~in_flush;
  assign do_issue    = in_fu_ready & any_elig & ~in_flush;
  assign new_rank    = do_issue ? RW'(occ - 1'b1) : RW'(occ);

`ifdef RS_DISPATCH_FWD_EN
  assign fwd_a = ~in_dispatch_a_ready & in_fu_done & (in_dispatch_a_tag == in_fu_dst_rob_index);
  assign fwd_b = ~in_dispatch_b_ready & in_fu_done & (in_dispatch_b_tag == in_fu_dst_rob_index);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (in_fu_done && entry_q[i].valid) begin
        if (!entry_q[i].a_rdy && entry_q[i].a_tag == in_fu_dst_rob_index) begin
          entry_d[i].a_rdy = 1'b1;
          entry_d[i].a_val = in_fu_value;
        end
        if (!entry_q[i].b_rdy && entry_q[i].b_tag == in_fu_dst_rob_index) begin
          entry_d[i].b_rdy = 1'b1;
          entry_d[i].b_val = in_fu_value;
        end
      end
      if (do_issue) begin
        if (sel_oh[i])
          entry_d[i].valid = 1'b0;
        else if (entry_q[i].valid && entry_q[i].rank > sel_rank)
          entry_d[i].rank = entry_q[i].rank - 1'b1;
      end
      // Free slot is chosen from pre-edge state, so a slot vacated by issue waits a cycle.
      if (do_dispatch && free_oh[i]) begin
        entry_d[i].valid    = 1'b1;
        entry_d[i].op       = in_dispatch_fu_op;
        entry_d[i].dst      = in_dispatch_dst_rob_index;
        entry_d[i].set_nzcv = in_dispatch_set_nzcv;
        entry_d[i].nzcv     = in_dispatch_nzcv;
        entry_d[i].a_rdy    = in_dispatch_a_ready | fwd_a;
        entry_d[i].a_val    = fwd_a ? in_fu_value : in_dispatch_a_val;
        entry_d[i].a_tag    = in_dispatch_a_tag;
        entry_d[i].b_rdy    = in_dispatch_b_ready | fwd_b;
        entry_d[i].b_val    = fwd_b ? in_fu_value : in_dispatch_b_val;
        entry_d[i].b_tag    = in_dispatch_b_tag;
        entry_d[i].rank     = new_rank;
      end
      if (in_flush) begin
        entry_d[i].valid = 1'b0;
        entry_d[i].rank  = '0;
      end
    end
  end

  always_comb begin
    fu_start_d = do_issue;
    fu_op_d    = fu_op_q;
    val_a_d    = val_a_q;
    val_b_d    = val_b_q;
    dst_d      = dst_q;
    set_nzcv_d = set_nzcv_q;
    nzcv_d     = nzcv_q;
    if (do_issue) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (sel_oh[i]) begin
          fu_op_d    = entry_q[i].op;
          val_a_d    = entry_q[i].a_val;
          val_b_d    = entry_q[i].b_val;
          dst_d      = entry_q[i].dst;
          set_nzcv_d = entry_q[i].set_nzcv;
          nzcv_d     = entry_q[i].nzcv;
        end
      end
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < RS_DEPTH; i++) entry_q[i] <= '0;
      fu_start_q <= 1'b0;
      fu_op_q    <= '0;
      val_a_q    <= '0;
      val_b_q    <= '0;
      dst_q      <= '0;
      set_nzcv_q <= 1'b0;
      nzcv_q     <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) entry_q[i] <= entry_d[i];
      fu_start_q <= fu_start_d;
      fu_op_q    <= fu_op_d;
      val_a_q    <= val_a_d;
      val_b_q    <= val_b_d;
      dst_q      <= dst_d;
      set_nzcv_q <= set_nzcv_d;
      nzcv_q     <= nzcv_d;
    end
  end

  assign out_fu_start         = fu_start_q;
  assign out_fu_fu_op         = fu_op_q;
  assign out_fu_val_a         = val_a_q;
  assign out_fu_val_b         = val_b_q;
  assign out_fu_dst_rob_index = dst_q;
  assign out_fu_set_nzcv      = set_nzcv_q;
  assign out_fu_nzcv          = nzcv_q;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station; checks RS_DISPATCH_FWD_EN behaviour when defined.
module tb_alu_reservation_station;
  logic        in_clk = 1'b0;
  logic        in_rst_n, in_flush;
  logic        in_dispatch_valid;
  logic [3:0]  in_dispatch_fu_op;
  logic [4:0]  in_dispatch_dst_rob_index;
  logic        in_dispatch_set_nzcv;
  logic [3:0]  in_dispatch_nzcv;
  logic        in_dispatch_a_ready, in_dispatch_b_ready;
  logic [31:0] in_dispatch_a_val, in_dispatch_b_val;
  logic [4:0]  in_dispatch_a_tag, in_dispatch_b_tag;
  logic        out_dispatch_ready;
  logic        in_fu_done;
  logic [4:0]  in_fu_dst_rob_index;
  logic [31:0] in_fu_value;
  logic        in_fu_ready;
  logic        out_fu_start;
  logic [3:0]  out_fu_fu_op;
  logic [31:0] out_fu_val_a, out_fu_val_b;
  logic [4:0]  out_fu_dst_rob_index;
  logic        out_fu_set_nzcv;
  logic [3:0]  out_fu_nzcv;

  int chk_cnt = 0;
  int err_cnt = 0;

  alu_reservation_station dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_flush(in_flush),
    .in_dispatch_valid(in_dispatch_valid), .in_dispatch_fu_op(in_dispatch_fu_op),
    .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
    .in_dispatch_set_nzcv(in_dispatch_set_nzcv), .in_dispatch_nzcv(in_dispatch_nzcv),
    .in_dispatch_a_ready(in_dispatch_a_ready), .in_dispatch_b_ready(in_dispatch_b_ready),
    .in_dispatch_a_val(in_dispatch_a_val), .in_dispatch_b_val(in_dispatch_b_val),
    .in_dispatch_a_tag(in_dispatch_a_tag), .in_dispatch_b_tag(in_dispatch_b_tag),
    .out_dispatch_ready(out_dispatch_ready),
    .in_fu_done(in_fu_done), .in_fu_dst_rob_index(in_fu_dst_rob_index),
    .in_fu_value(in_fu_value), .in_fu_ready(in_fu_ready),
    .out_fu_start(out_fu_start), .out_fu_fu_op(out_fu_fu_op),
    .out_fu_val_a(out_fu_val_a), .out_fu_val_b(out_fu_val_b),
    .out_fu_dst_rob_index(out_fu_dst_rob_index),
    .out_fu_set_nzcv(out_fu_set_nzcv), .out_fu_nzcv(out_fu_nzcv)
  );

  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] dst,
                      input logic ar, input logic [31:0] av, input logic [4:0] at,
                      input logic br, input logic [31:0] bv, input logic [4:0] bt);
    in_dispatch_valid         = 1'b1;
    in_dispatch_fu_op         = op;
    in_dispatch_dst_rob_index = dst;
    in_dispatch_a_ready       = ar;
    in_dispatch_a_val         = av;
    in_dispatch_a_tag         = at;
    in_dispatch_b_ready       = br;
    in_dispatch_b_val         = bv;
    in_dispatch_b_tag         = bt;
    tick();
    in_dispatch_valid = 1'b0;
  endtask

  task automatic chk_issue(input string tag, input logic [4:0] dst,
                           input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_start"}, 64'(out_fu_start), 64'd1);
    chk({tag, "_dst"}, 64'(out_fu_dst_rob_index), 64'(dst));
    chk({tag, "_val_a"}, 64'(out_fu_val_a), 64'(a));
    chk({tag, "_val_b"}, 64'(out_fu_val_b), 64'(b));
  endtask

  initial begin
    in_rst_n = 1'b0; in_flush = 1'b0; in_dispatch_valid = 1'b0;
    in_dispatch_fu_op = '0; in_dispatch_dst_rob_index = '0;
    in_dispatch_set_nzcv = 1'b0; in_dispatch_nzcv = '0;
    in_dispatch_a_ready = 1'b0; in_dispatch_b_ready = 1'b0;
    in_dispatch_a_val = '0; in_dispatch_b_val = '0;
    in_dispatch_a_tag = '0; in_dispatch_b_tag = '0;
    in_fu_done = 1'b0; in_fu_dst_rob_index = '0; in_fu_value = '0; in_fu_ready = 1'b0;

    #12;
    chk("rst_start", 64'(out_fu_start), 64'd0);
    chk("rst_dst", 64'(out_fu_dst_rob_index), 64'd0);
    chk("rst_val_a", 64'(out_fu_val_a), 64'd0);
    chk("rst_disp_ready", 64'(out_dispatch_ready), 64'd1);
    in_rst_n = 1'b1;
    tick();

    // basic issue with flags payload
    in_fu_ready = 1'b1;
    in_dispatch_set_nzcv = 1'b1; in_dispatch_nzcv = 4'hA;
    disp(4'd1, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    in_dispatch_set_nzcv = 1'b0; in_dispatch_nzcv = 4'h0;
    chk("t1_no_early", 64'(out_fu_start), 64'd0);
    tick();
    chk_issue("t1", 5'd3, 32'd5, 32'd7);
    chk("t1_op", 64'(out_fu_fu_op), 64'd1);
    chk("t1_setf", 64'(out_fu_set_nzcv), 64'd1);
    chk("t1_nzcv", 64'(out_fu_nzcv), 64'hA);
    tick();
    chk("t1_one_cycle", 64'(out_fu_start), 64'd0);

    // wakeup via broadcast, not eligible in the same edge
    disp(4'd2, 5'd4, 1'b0, 32'd0, 5'd2, 1'b1, 32'd1, 5'd0);
    chk("t2_pending", 64'(out_fu_start), 64'd0);
    in_fu_done = 1'b1; in_fu_dst_rob_index = 5'd2; in_fu_value = 32'd40;
    tick();
    in_fu_done = 1'b0;
    chk("t2_no_same_edge", 64'(out_fu_start), 64'd0);
    tick();
    chk_issue("t2", 5'd4, 32'd40, 32'd1);
    tick();
    chk("t2_end", 64'(out_fu_start), 64'd0);

    // fill, drop fifth, drain in order
    in_fu_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      disp(4'd3, 5'(10 + k), 1'b1, 32'(100 + k), 5'd0, 1'b1, 32'(k), 5'd0);
    chk("t3_full", 64'(out_dispatch_ready), 64'd0);
    disp(4'd3, 5'd14, 1'b1, 32'd200, 5'd0, 1'b1, 32'd0, 5'd0);
    chk("t3_full_after_drop", 64'(out_dispatch_ready), 64'd0);
    chk("t3_no_issue_not_ready", 64'(out_fu_start), 64'd0);
    in_fu_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_issue("t3_drain", 5'(10 + k), 32'(100 + k), 32'(k));
    end
    tick();
    chk("t3_fifth_dropped", 64'(out_fu_start), 64'd0);
    chk("t3_empty_ready", 64'(out_dispatch_ready), 64'd1);

    // dispatch and issue on the same edge, back-to-back issue
    disp(4'd4, 5'd30, 1'b1, 32'd300, 5'd0, 1'b1, 32'd1, 5'd0);
    chk("t4_first_wait", 64'(out_fu_start), 64'd0);
    disp(4'd4, 5'd31, 1'b1, 32'd301, 5'd0, 1'b1, 32'd2, 5'd0);
    chk_issue("t4_a", 5'd30, 32'd300, 32'd1);
    tick();
    chk_issue("t4_b", 5'd31, 32'd301, 32'd2);
    tick();
    chk("t4_end", 64'(out_fu_start), 64'd0);

    // age ordering
    in_fu_ready = 1'b0;
    disp(4'd5, 5'd20, 1'b0, 32'd0, 5'd7, 1'b1, 32'd0, 5'd0);
    disp(4'd5, 5'd21, 1'b0, 32'd0, 5'd8, 1'b1, 32'd1, 5'd0);
    disp(4'd5, 5'd22, 1'b0, 32'd0, 5'd9, 1'b1, 32'd2, 5'd0);
    in_fu_done = 1'b1; in_fu_dst_rob_index = 5'd8; in_fu_value = 32'd80;
    tick();
    in_fu_done = 1'b0; in_fu_ready = 1'b1;
    tick();
    chk_issue("t5_younger", 5'd21, 32'd80, 32'd1);
    in_fu_ready = 1'b0;
    in_fu_done = 1'b1; in_fu_dst_rob_index = 5'd9; in_fu_value = 32'd90;
    tick();
    chk("t5_hold1", 64'(out_fu_start), 64'd0);
    in_fu_dst_rob_index = 5'd7; in_fu_value = 32'd70;
    tick();
    chk("t5_hold2", 64'(out_fu_start), 64'd0);
    in_fu_done = 1'b0; in_fu_ready = 1'b1;
    tick();
    chk_issue("t5_oldest", 5'd20, 32'd70, 32'd0);
    tick();
    chk_issue("t5_last", 5'd22, 32'd90, 32'd2);
    tick();
    chk("t5_end", 64'(out_fu_start), 64'd0);

    // flush
    in_fu_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      disp(4'd6, 5'(1 + k), 1'b1, 32'(k), 5'd0, 1'b1, 32'(k), 5'd0);
    in_fu_ready = 1'b1; in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("t6_flush_no_start", 64'(out_fu_start), 64'd0);
    chk("t6_flush_ready", 64'(out_dispatch_ready), 64'd1);
    tick();
    chk("t6_no_later1", 64'(out_fu_start), 64'd0);
    tick();
    chk("t6_no_later2", 64'(out_fu_start), 64'd0);

    // async reset mid-cycle
    in_fu_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      disp(4'd7, 5'(16 + k), 1'b1, 32'(k), 5'd0, 1'b1, 32'(k), 5'd0);
    chk("t7_full", 64'(out_dispatch_ready), 64'd0);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk("t7_async_ready", 64'(out_dispatch_ready), 64'd1);
    chk("t7_async_dst", 64'(out_fu_dst_rob_index), 64'd0);
    chk("t7_async_val_a", 64'(out_fu_val_a), 64'd0);
    in_rst_n = 1'b1;
    tick();
    in_fu_ready = 1'b1;
    tick();
    chk("t7_no_issue", 64'(out_fu_start), 64'd0);

    // dispatch-time forwarding
    in_fu_done = 1'b1; in_fu_dst_rob_index = 5'd6; in_fu_value = 32'd99;
    disp(4'd8, 5'd25, 1'b0, 32'd0, 5'd6, 1'b1, 32'd2, 5'd0);
    in_fu_done = 1'b0;
    chk("t8_wait", 64'(out_fu_start), 64'd0);
    tick();
`ifdef RS_DISPATCH_FWD_EN
    chk_issue("t8_fwd", 5'd25, 32'd99, 32'd2);
`else
    chk("t8_nofwd_start", 64'(out_fu_start), 64'd0);
`endif
    tick();
    chk("t8_end", 64'(out_fu_start), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end
endmodule
